iter_divider: RTL and testbench

- Multi-cycle 32-bit integer divide unit implementing RV32M DIV, DIVU, REM and REMU.
- Sits beside the ALU in execute.
- RESULT feeds IN_1 of the writeback-select 2:1 mux; the ALU result feeds IN_0.
- The control unit holds the pipeline while BUSY is high and raises the mux select on DONE.

---
 rtl/div_pkg.sv | 23 ++
 rtl/iter_divider.sv | 168 ++++++++++++++++
 tb/tb_iter_divider.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divide unit.
//   div_op_t    : operation encoding carried on OP (DIV, DIVU, REM, REMU)
//   div_state_t : sequencer states (IDLE, CALC, FIN)
//   DIV_BY_ZERO_Q / SIGNED_MIN : architectural special-case values (32-bit)
package div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIN  = 2'b10
    } div_state_t;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] SIGNED_MIN    = 32'h8000_0000;

endpackage

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
// One shift-subtract step per cycle on absolute values; signs are applied
// when the result is registered in FIN.
//
// State   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for START; operands and op captured on acceptance
// CALC    | WIDTH shift-subtract steps, count runs WIDTH..1
// FIN     | sign-correct and register RESULT, pulse DONE, back to IDLE
//
// Ports:
//   CLK    in   rising-edge clock
//   RST    in   synchronous active-high reset
//   START  in   request pulse, only sampled while BUSY=0
//   OP     in   [1:0] div_op_t encoding
//   A, B   in   [WIDTH-1:0] dividend / divisor
//   BUSY   out  state != IDLE
//   DONE   out  one-cycle pulse, RESULT valid in the same cycle
//   RESULT out  [WIDTH-1:0] quotient or remainder, held until next DONE
module iter_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT
);

    localparam int               CNT_W   = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] ONES    = '1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state, state_nxt;
    div_op_t          op_q;
    logic [WIDTH-1:0] quot;      // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   rem;
    logic [CNT_W-1:0] count;
    logic             neg_q, neg_r;

    div_op_t          op_in;
    logic             in_signed, div_zero, ovf;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   rem_sh, rem_step;
    logic [WIDTH+1:0] diff;
    logic             borrow;
    logic [WIDTH-1:0] quot_step, rem_lo, res_fin;

    // Operand conditioning and the shift-subtract step.
    always_comb begin
        op_in     = div_op_t'(OP);
        in_signed = (op_in == DIV) || (op_in == REM);
        // -MIN wraps back to MIN, which is the correct unsigned magnitude.
        a_abs     = (in_signed && A[WIDTH-1]) ? -A : A;
        b_abs     = (in_signed && B[WIDTH-1]) ? -B : B;
        div_zero  = (B == '0);
        ovf       = in_signed && (A == MIN_VAL) && (B == ONES);

        rem_sh    = {rem[WIDTH-1:0], quot[WIDTH-1]};
        // Extra top bit acts as the borrow out of the WIDTH+1 bit subtract.
        diff      = {1'b0, rem_sh} - {2'b00, dvs};
        borrow    = diff[WIDTH+1];
        rem_step  = borrow ? rem_sh : diff[WIDTH:0];
        quot_step = {quot[WIDTH-2:0], ~borrow};

        rem_lo    = rem[WIDTH-1:0];
        if ((op_q == REM) || (op_q == REMU)) begin
            res_fin = neg_r ? -rem_lo : rem_lo;
        end else begin
            res_fin = neg_q ? -quot : quot;
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (START) begin
                    state_nxt = (div_zero || ovf) ? FIN : CALC;
                end
            end
            CALC: begin
                if (count == CNT_W'(1)) begin
                    state_nxt = FIN;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        BUSY = (state != IDLE);
    end

    // Datapath.
    always_ff @(posedge CLK) begin
        if (RST) begin
            op_q   <= DIV;
            quot   <= '0;
            dvs    <= '0;
            rem    <= '0;
            count  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            DONE   <= 1'b0;
            RESULT <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        op_q  <= op_in;
                        dvs   <= b_abs;
                        count <= CNT_W'(WIDTH);
                        // Special cases preload the final magnitudes with no
                        // sign correction so FIN can treat them uniformly.
                        if (div_zero) begin
                            quot  <= ONES;
                            rem   <= {1'b0, A};
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                        end else if (ovf) begin
                            quot  <= MIN_VAL;
                            rem   <= '0;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                        end else begin
                            quot  <= a_abs;
                            rem   <= '0;
                            neg_q <= in_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                            neg_r <= in_signed && A[WIDTH-1];
                        end
                    end
                end
                CALC: begin
                    rem   <= rem_step;
                    quot  <= quot_step;
                    count <= count - CNT_W'(1);
                end
                FIN: begin
                    RESULT <= res_fin;
                    DONE   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: the driver pushes the reference
// result for every accepted request, an independent monitor pops and
// compares on every DONE, including DONE-to-DONE latency.
module tb_iter_divider;
    import div_pkg::*;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST, START;
    logic [1:0]   OP;
    logic [W-1:0] A, B;
    logic         BUSY, DONE;
    logic [W-1:0] RESULT;

    iter_divider #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .START(START), .OP(OP), .A(A), .B(B),
        .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [W-1:0] res;
        int           acc;
        bit           special;
        string        name;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    bit   prev_done = 1'b0;
    int   lat;

    function automatic void check(string name, logic [W-1:0] act, logic [W-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    endfunction

    function automatic bit is_special(div_op_t op, logic [W-1:0] a, logic [W-1:0] b);
        return (b == 0) || ((op == DIV || op == REM) && a == SIGNED_MIN && b == 32'hFFFF_FFFF);
    endfunction

    // Architectural RV32M results straight from integer arithmetic.
    function automatic logic [W-1:0] ref_model(div_op_t op, logic [W-1:0] a, logic [W-1:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 0) return (op == DIV || op == DIVU) ? DIV_BY_ZERO_Q : a;
        if ((op == DIV || op == REM) && a == SIGNED_MIN && b == 32'hFFFF_FFFF)
            return (op == DIV) ? SIGNED_MIN : 32'h0;
        case (op)
            DIV:     return 32'(sa / sb);
            REM:     return 32'(sa % sb);
            DIVU:    return a / b;
            default: return a % b;
        endcase
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return SIGNED_MIN;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every DONE must match the oldest outstanding request.
    always @(negedge CLK) begin
        if (DONE === 1'b1) begin
            check("done_pulse_width", {31'b0, prev_done}, 32'h0);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: DONE with nothing pending, RESULT=0x%08h", RESULT);
            end else begin
                e   = exp_q.pop_front();
                check(e.name, RESULT, e.res);
                lat = cyc - 1 - e.acc;
                if (e.special) begin
                    n_checks++;
                    if (lat >= 1 && lat <= 2) n_pass++;
                    else $display("FAIL %s_latency: got %0d cycles expected 1..2", e.name, lat);
                end else begin
                    check({e.name, "_latency"}, 32'(lat), 32'd33);
                end
            end
        end
        prev_done = (DONE === 1'b1);
    end

    // Must be called at a negedge; returns at the negedge after acceptance.
    task automatic issue(input div_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit track, input string name, output int acc);
        int guard = 0;
        while (BUSY !== 1'b0 && guard < 100) begin
            @(negedge CLK);
            guard++;
        end
        if (BUSY !== 1'b0) begin
            n_checks++;
            $display("FAIL issue_wait_%s: BUSY=%b expected 0", name, BUSY);
        end
        START = 1'b1;
        OP    = op;
        A     = a;
        B     = b;
        acc   = cyc;
        if (track) exp_q.push_back('{ref_model(op, a, b), cyc, is_special(op, a, b), name});
        @(negedge CLK);
        START = 1'b0;
        A     = $urandom;
        B     = $urandom;
        OP    = 2'($urandom);
    endtask

    task automatic drain(input string name);
        int g = 0;
        while ((exp_q.size() != 0 || BUSY !== 1'b0) && g < 200) begin
            @(negedge CLK);
            g++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL %s_drain: %0d results missing, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int acc, acc2, busy_bad, g;
        div_op_t rop;

        RST = 1'b1; START = 1'b0; OP = 2'b00; A = '0; B = '0;
        repeat (3) @(negedge CLK);
        check("reset_busy",   {31'b0, BUSY}, 32'h0);
        check("reset_done",   {31'b0, DONE}, 32'h0);
        check("reset_result", RESULT, 32'h0);
        RST = 1'b0;
        @(negedge CLK);

        // BUSY window for a normal op: high after edges acc..acc+32.
        issue(DIVU, 32'd100, 32'd7, 1'b1, "divu_100_7", acc);
        busy_bad = 0;
        for (int i = 0; i < 33; i++) begin
            if (BUSY !== 1'b1) busy_bad++;
            if (i < 32) @(negedge CLK);
        end
        @(negedge CLK);
        check("busy_window_errors", 32'(busy_bad), 32'h0);
        check("busy_low_at_done",   {31'b0, BUSY}, 32'h0);
        check("done_at_edge_33",    {31'b0, DONE}, 32'h1);
        issue(REMU, 32'd100, 32'd7, 1'b1, "remu_100_7", acc);
        drain("basic");

        issue(DIV,  32'hFFFF_FFF9, 32'd2,        1'b1, "div_m7_2",   acc);
        issue(REM,  32'hFFFF_FFF9, 32'd2,        1'b1, "rem_m7_2",   acc);
        issue(REM,  32'd7,         32'hFFFF_FFFE, 1'b1, "rem_7_m2",  acc);
        issue(DIV,  SIGNED_MIN,    32'hFFFF_FFFF, 1'b1, "div_ovf",   acc);
        issue(REM,  SIGNED_MIN,    32'hFFFF_FFFF, 1'b1, "rem_ovf",   acc);
        issue(DIVU, SIGNED_MIN,    32'hFFFF_FFFF, 1'b1, "divu_min_ones", acc);
        issue(DIVU, 32'h1234,      32'h0,        1'b1, "divu_by_0",  acc);
        issue(REMU, 32'h1234,      32'h0,        1'b1, "remu_by_0",  acc);
        issue(DIV,  32'hFFFF_FFFB, 32'h0,        1'b1, "div_m5_by_0", acc);
        issue(REM,  32'hFFFF_FFFB, 32'h0,        1'b1, "rem_m5_by_0", acc);
        drain("directed");

        // Reset mid-operation discards the op.
        issue(DIVU, 32'd1000, 32'd10, 1'b0, "rst_victim", acc);
        while (cyc < acc + 10) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("midrst_busy",   {31'b0, BUSY}, 32'h0);
        check("midrst_done",   {31'b0, DONE}, 32'h0);
        check("midrst_result", RESULT, 32'h0);
        RST = 1'b0;
        repeat (40) @(negedge CLK);
        issue(DIVU, 32'd1000, 32'd10, 1'b1, "divu_after_rst", acc);
        drain("reset");

        // START while busy is ignored; START in the DONE cycle is taken.
        issue(DIVU, 32'hDEAD_BEEF, 32'h1234, 1'b1, "divu_ignore", acc);
        while (cyc < acc + 5) @(negedge CLK);
        START = 1'b1; OP = 2'(DIV); A = 32'd77; B = 32'd3;
        @(negedge CLK);
        START = 1'b0;
        while (cyc < acc + 20) @(negedge CLK);
        START = 1'b1; OP = 2'(REMU); A = 32'd55; B = 32'd0;
        @(negedge CLK);
        START = 1'b0;
        g = 0;
        while (DONE !== 1'b1 && g < 100) begin
            @(negedge CLK);
            g++;
        end
        check("b2b_done_seen", {31'b0, DONE}, 32'h1);
        issue(REM, 32'hFFFF_F000, 32'd77, 1'b1, "rem_b2b", acc2);
        check("b2b_busy_next", {31'b0, BUSY}, 32'h1);
        drain("b2b");

        for (int i = 0; i < 40; i++) begin
            rop = div_op_t'($urandom_range(0, 3));
            issue(rop, pick(), pick(), 1'b1, $sformatf("rand%0d_%s", i, rop.name()), acc);
        end
        drain("random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
